fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC, issues ibus fetches, fills the D register
//  (D_type {pc, imp}) that the decode stage reads. Applies decode's jump/branch redirect after
//  the delay slot. Honours decode's load-use stall (F_st/D_st).
//  Inserts a NOP bubble while instruction memory is slow.
// PARAMETERS
//  RESET_PC   32'hbfc0_0000  first fetch address after reset
// PORTS
//  clk         in   1    core clock; every register updates on posedge
//  reset       in   1    synchronous, active-high reset
//  ireq        out  ibus_req_t   {valid, addr}; instruction bus request
//  iresp       in   ibus_resp_t  {addr_ok, data_ok, data}; instruction bus response
//  F_st        in   1    from decode: hold PC / fetch state this cycle
//  D_st        in   1    from decode: hold D register this cycle
//  ifj         in   1    from decode: instruction in D redirects control flow
//  pc_decode   in   32   from decode: redirect target (valid when ifj=1)
//  D           out  D_type  decode-stage register {pc, imp}
// BEHAVIOUR
//  Reset (clk edge with reset=1): pc_f=RESET_PC, state=REQ, redir_pend=0, D='0 (pc=0, imp=0 = NOP);
//   ireq.valid=0 during the reset cycle, 1 from the first cycle after.
//  FSM, 3 states:
//   REQ   : ireq.valid=1, ireq.addr=pc_f. Addr and valid held constant until data_ok.
//           On iresp.data_ok -> instruction word ready.
//   HOLD  : word captured in ibuf; downstream stalled. ireq.valid=0. Leave when D_st=0.
//   DROP  : reset deasserted mid-redirect is impossible. DROP is entered only when a stray
//           response is owed. It is reserved for a request whose addr was accepted
//           (addr_ok) but must be discarded. Wait for data_ok, ignore data, go to REQ.
//  D register update (priority high->low):
//   reset -> '0;  D_st=1 -> hold;  word ready (data_ok in REQ, or HOLD exit) ->
//   {pc_f, word}.  Otherwise -> bubble '0.
//  Word ready while D_st=1 -> capture into ibuf, state=HOLD; D keeps old value.
//  PC advance: when the word is consumed into D, pc_f <= redir_pend ? redir_tgt : pc_f+4.
//   redir_pend clears in the same cycle.
//  Redirect: sample ifj only when D_st=0 (ifj computed during a stall uses stale operands).
//   On ifj=1: redir_pend<=1, redir_tgt<=pc_decode.
//   The in-flight/next fetch is the delay slot and is delivered unchanged. The fetch after
//   it uses the target.
//   ifj when the delay-slot word is consumed the same cycle -> pc_f loads pc_decode directly.
//   Address: 32-bit wrap on +4 with no trap. A misaligned redirect target is passed unchanged.
//  F_st=1: no PC advance, no new request launch. An accepted request still completes into ibuf.
//  Simultaneous reset with data_ok: reset wins. The late data_ok for the killed request
//   arrives after reset. It is absorbed via DROP when reset occurred with addr_ok already seen.
//  Latency: zero-wait ibus -> one instruction per cycle. N-cycle memory -> N-1 bubbles.
//  Registers: pc_f, state, redir_pend, redir_tgt, ibuf, D.
//  Outputs driven only from these registers.
// STRUCTURE
//  pipeline.svh/package: D_type, i32, ibus_req_t/ibus_resp_t, fetch_state_t {REQ,HOLD,DROP},
//   RESET_PC constant.
//  No sub-module. A single always_ff plus one always_comb for next-state and request.
// TESTING
//  1 reset, zero-wait ibus returning 0x24080001 -> ireq.addr bfc00000, bfc00004, ...
//    D.pc follows one cycle later, one per cycle.
//  2 3-cycle data_ok latency -> ireq.addr held stable. D = '0 for 2 cycles, then {bfc00000,word}.
//  3 D holds j at bfc00010, ifj=1, pc_decode=bfc00100 -> next D.pc=bfc00014 (delay slot),
//    then bfc00100.
//  4 data_ok while D_st=1 for 2 cycles -> D unchanged, ireq.valid=0.
//    Then D={pc,word} on the first D_st=0 cycle with no refetch.
//  5 ifj=1 with D_st=1 -> ignored. ifj=1 next cycle with D_st=0 -> redirect applied exactly once.
//  6 reset pulse mid-request (addr_ok seen) -> stray data_ok dropped.
//    First D after reset = {bfc00000, word}.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage of the 5-stage MIPS pipeline.
// Provides the instruction bus request/response structs, the decode register
// type, the fetch FSM state encoding and the architectural reset vector.
package fetch_stage_pkg;

  typedef logic [31:0] i32;

  localparam i32 RESET_PC = 32'hbfc0_0000;
  localparam i32 PC_STEP  = 32'd4;

  // Decode-stage register: fetched PC plus the raw instruction word.
  typedef struct packed {
    i32 pc;
    i32 imp;
  } D_type;

  typedef struct packed {
    logic valid;
    i32   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    i32   data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Sequential successor; plain 32-bit wrap, no address trap.
  function automatic i32 next_seq_pc(input i32 pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues instruction bus requests and fills the
// D register read by decode. Applies decode's jump/branch redirect after the
// delay slot, honours the load-use stall, and emits NOP bubbles while the
// instruction memory is slow.
//
// Ports
//   clk        core clock, all state updates on posedge
//   reset      synchronous active-high reset
//   ireq       instruction bus request {valid, addr}
//   iresp      instruction bus response {addr_ok, data_ok, data}
//   F_st       decode asks fetch to hold the PC / not launch a new fetch
//   D_st       decode asks to hold the D register
//   ifj        instruction currently in D redirects control flow
//   pc_decode  redirect target, meaningful while ifj=1
//   D          decode-stage register {pc, imp}
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter i32 RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic       clk,
  input  logic       reset,
  output ibus_req_t  ireq,
  input  ibus_resp_t iresp,
  input  logic       F_st,
  input  logic       D_st,
  input  logic       ifj,
  input  i32         pc_decode,
  output D_type      D
);

  i32           pc_f_r;
  fetch_state_t state_r;
  logic         redir_pend_r;
  i32           redir_tgt_r;
  i32           ibuf_r;
  logic         addr_acc_r;   // address accepted, data beat still owed
  D_type        d_r;

  logic         stall_s;
  logic         redir_take_s;
  logic         word_rdy_s;
  i32           word_s;
  logic         consume_s;
  logic         owed_s;
  i32           pc_tgt_s;
  fetch_state_t state_nxt_s;
  logic         addr_acc_nxt_s;
  i32           ibuf_nxt_s;
  i32           pc_nxt_s;
  logic         redir_pend_nxt_s;
  i32           redir_tgt_nxt_s;
  D_type        d_nxt_s;

  // Request is live in REQ only; reset forces it low in the reset cycle itself.
  assign ireq = '{valid: (state_r == REQ) && !reset, addr: pc_f_r};
  assign D    = d_r;

  // Next-state, word selection, PC / redirect bookkeeping and D update.
  always_comb begin
    // A word is only handed to decode when neither stall is active, so the
    // PC never advances without its word landing in D.
    stall_s        = D_st | F_st;
    // ifj computed during a decode stall uses stale operands.
    redir_take_s   = ifj & ~D_st;
    word_rdy_s     = 1'b0;
    word_s         = ibuf_r;
    state_nxt_s    = state_r;
    addr_acc_nxt_s = addr_acc_r;
    ibuf_nxt_s     = ibuf_r;
    owed_s         = addr_acc_r & ~iresp.data_ok;

    case (state_r)
      REQ: begin
        if (iresp.data_ok) begin
          word_rdy_s     = 1'b1;
          word_s         = iresp.data;
          addr_acc_nxt_s = 1'b0;
          if (stall_s) begin
            state_nxt_s = HOLD;
            ibuf_nxt_s  = iresp.data;
          end else begin
            state_nxt_s = REQ;
          end
        end else if (iresp.addr_ok) begin
          addr_acc_nxt_s = 1'b1;
        end else begin
          addr_acc_nxt_s = addr_acc_r;
        end
      end
      HOLD: begin
        word_rdy_s     = 1'b1;
        addr_acc_nxt_s = 1'b0;
        if (stall_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DROP: begin
        // Stray beat of a request killed by reset: discard its data.
        if (iresp.data_ok) begin
          state_nxt_s    = REQ;
          addr_acc_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = DROP;
          addr_acc_nxt_s = addr_acc_r;
        end
      end
      default: begin
        state_nxt_s    = REQ;
        addr_acc_nxt_s = 1'b0;
      end
    endcase

    consume_s = word_rdy_s & ~stall_s;

    // The word being consumed is the delay slot whenever a redirect is known.
    if (redir_pend_r) begin
      pc_tgt_s = redir_tgt_r;
    end else if (redir_take_s) begin
      pc_tgt_s = pc_decode;
    end else begin
      pc_tgt_s = next_seq_pc(pc_f_r);
    end

    if (consume_s) begin
      pc_nxt_s         = pc_tgt_s;
      redir_pend_nxt_s = 1'b0;
      redir_tgt_nxt_s  = redir_tgt_r;
    end else if (redir_take_s) begin
      pc_nxt_s         = pc_f_r;
      redir_pend_nxt_s = 1'b1;
      redir_tgt_nxt_s  = pc_decode;
    end else begin
      pc_nxt_s         = pc_f_r;
      redir_pend_nxt_s = redir_pend_r;
      redir_tgt_nxt_s  = redir_tgt_r;
    end

    if (D_st) begin
      d_nxt_s = d_r;
    end else if (consume_s) begin
      d_nxt_s.pc  = pc_f_r;
      d_nxt_s.imp = word_s;
    end else begin
      d_nxt_s = '0;
    end
  end

  // State registers; reset parks in DROP when a data beat is still owed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_r       <= RESET_PC;
      state_r      <= owed_s ? DROP : REQ;
      addr_acc_r   <= owed_s;
      redir_pend_r <= 1'b0;
      redir_tgt_r  <= 32'h0000_0000;
      ibuf_r       <= 32'h0000_0000;
      d_r          <= '0;
    end else begin
      pc_f_r       <= pc_nxt_s;
      state_r      <= state_nxt_s;
      addr_acc_r   <= addr_acc_nxt_s;
      redir_pend_r <= redir_pend_nxt_s;
      redir_tgt_r  <= redir_tgt_nxt_s;
      ibuf_r       <= ibuf_nxt_s;
      d_r          <= d_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle table under a zero-wait bus,
// plus hand sequences for slow memory, redirect pending and reset-drop.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       F_st;
  logic       D_st;
  logic       ifj;
  i32         pc_decode;
  D_type      D;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state
  int          mem_lat  = 0;
  logic        m_busy   = 1'b0;
  int          m_cnt    = 0;
  logic [31:0] m_addr   = 32'h0;
  logic        m_poison = 1'b0;

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iresp     (iresp),
    .F_st      (F_st),
    .D_st      (D_st),
    .ifj       (ifj),
    .pc_decode (pc_decode),
    .D         (D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h2408_0000 | {16'h0000, a[15:0]};
  endfunction

  // Response side: combinational when zero-wait, otherwise one outstanding
  // request answered mem_lat-1 cycles after acceptance.
  always_comb begin
    if (mem_lat == 0) begin
      iresp.addr_ok = ireq.valid;
      iresp.data_ok = ireq.valid;
      iresp.data    = word_of(ireq.addr);
    end else begin
      iresp.addr_ok = ireq.valid && !m_busy;
      iresp.data_ok = m_busy && (m_cnt == mem_lat - 1);
      iresp.data    = m_poison ? (word_of(m_addr) ^ 32'hdead_beef) : word_of(m_addr);
    end
  end

  always @(posedge clk) begin
    if (mem_lat != 0) begin
      if (m_busy) begin
        if (iresp.data_ok) m_busy <= 1'b0;
        else m_cnt <= m_cnt + 1;
        if (reset) m_poison <= 1'b1;
      end else if (ireq.valid) begin
        m_busy   <= 1'b1;
        m_cnt    <= 1;
        m_addr   <= ireq.addr;
        m_poison <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        d_st;
    logic        ifj;
    logic [31:0] pc_dec;
    logic [31:0] e_pc;
    logic [31:0] e_imp;
    logic        e_valid;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_d(input string name, input int max);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (D.pc != 32'h0 || D.imp != 32'h0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic do_reset(input int lat);
    reset     = 1'b1;
    mem_lat   = lat;
    F_st      = 1'b0;
    D_st      = 1'b0;
    ifj       = 1'b0;
    pc_decode = 32'h0;
    step();
    step();
    check("rst_valid_low", {31'b0, ireq.valid}, 32'd0);
    check("rst_d_pc", D.pc, 32'h0);
    check("rst_d_imp", D.imp, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_valid_high", {31'b0, ireq.valid}, 32'd1);
    check("rst_addr", ireq.addr, 32'hbfc0_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                d_st  ifj   pc_dec        e_pc          e_imp         vld   e_addr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'hbfc00000, 32'h24080000, 1'b1, 32'hbfc00004};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'hbfc00004, 32'h24080004, 1'b1, 32'hbfc00008};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'hbfc00008, 32'h24080008, 1'b1, 32'hbfc0000c};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'hbfc00008, 32'h24080008, 1'b0, 32'hbfc0000c};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'hbfc00008, 32'h24080008, 1'b0, 32'hbfc0000c};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'hbfc0000c, 32'h2408000c, 1'b1, 32'hbfc00010};
    vecs[6]  = '{1'b1, 1'b1, 32'hbfc00300, 32'hbfc0000c, 32'h2408000c, 1'b0, 32'hbfc00010};
    vecs[7]  = '{1'b0, 1'b1, 32'hbfc00200, 32'hbfc00010, 32'h24080010, 1'b1, 32'hbfc00200};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'hbfc00200, 32'h24080200, 1'b1, 32'hbfc00204};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'hbfc00204, 32'h24080204, 1'b1, 32'hbfc00208};
    vecs[10] = '{1'b0, 1'b1, 32'hfffffffc, 32'hbfc00208, 32'h24080208, 1'b1, 32'hfffffffc};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'hfffffffc, 32'h2408fffc, 1'b1, 32'h00000000};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h00000000, 32'h24080000, 1'b1, 32'h00000004};
    vecs[13] = '{1'b0, 1'b1, 32'h00000102, 32'h00000004, 32'h24080004, 1'b1, 32'h00000102};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h00000102, 32'h24080102, 1'b1, 32'h00000106};

    // Zero-wait stream, decode stall/HOLD, stale ifj, wrap and misaligned target
    do_reset(0);
    for (int i = 0; i < 15; i++) begin
      D_st      = vecs[i].d_st;
      ifj       = vecs[i].ifj;
      pc_decode = vecs[i].pc_dec;
      step();
      check($sformatf("vec%0d_pc", i), D.pc, vecs[i].e_pc);
      check($sformatf("vec%0d_imp", i), D.imp, vecs[i].e_imp);
      check($sformatf("vec%0d_valid", i), {31'b0, ireq.valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d_addr", i), ireq.addr, vecs[i].e_addr);
    end
    D_st = 1'b0;
    ifj  = 1'b0;

    // Jump at bfc00010: delay slot bfc00014 delivered, then target
    do_reset(0);
    for (int i = 0; i < 20; i++) begin
      if (D.pc == 32'hbfc0_0010) break;
      step();
    end
    check("j_found", D.pc, 32'hbfc0_0010);
    ifj       = 1'b1;
    pc_decode = 32'hbfc0_0100;
    step();
    ifj = 1'b0;
    check("j_slot_pc", D.pc, 32'hbfc0_0014);
    check("j_slot_imp", D.imp, 32'h2408_0014);
    check("j_addr", ireq.addr, 32'hbfc0_0100);
    step();
    check("j_tgt_pc", D.pc, 32'hbfc0_0100);
    check("j_tgt_imp", D.imp, 32'h2408_0100);
    step();
    check("j_tgt4_pc", D.pc, 32'hbfc0_0104);

    // Three-cycle memory: two bubbles, stable address, then the word
    do_reset(3);
    step();
    check("slow1_d", D.pc | D.imp, 32'h0);
    check("slow1_addr", ireq.addr, 32'hbfc0_0000);
    check("slow1_valid", {31'b0, ireq.valid}, 32'd1);
    step();
    check("slow2_d", D.pc | D.imp, 32'h0);
    check("slow2_addr", ireq.addr, 32'hbfc0_0000);
    step();
    check("slow3_pc", D.pc, 32'hbfc0_0000);
    check("slow3_imp", D.imp, 32'h2408_0000);
    check("slow3_addr", ireq.addr, 32'hbfc0_0004);

    // Reset while bfc00004 is accepted but unanswered: stray beat dropped
    step();
    check("drop_pre_d", D.pc | D.imp, 32'h0);
    reset = 1'b1;
    #1;
    check("drop_rst_valid", {31'b0, ireq.valid}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("drop_valid", {31'b0, ireq.valid}, 32'd0);
    wait_d("drop_wait", 15);
    check("drop_pc", D.pc, 32'hbfc0_0000);
    check("drop_imp", D.imp, 32'h2408_0000);

    // Redirect seen while the delay slot is still in flight (pending path)
    ifj       = 1'b1;
    pc_decode = 32'hbfc0_0100;
    step();
    ifj = 1'b0;
    check("pend_bubble", D.pc | D.imp, 32'h0);
    wait_d("pend_wait1", 10);
    check("pend_slot_pc", D.pc, 32'hbfc0_0004);
    check("pend_slot_imp", D.imp, 32'h2408_0004);
    check("pend_addr", ireq.addr, 32'hbfc0_0100);
    wait_d("pend_wait2", 10);
    check("pend_tgt_pc", D.pc, 32'hbfc0_0100);
    check("pend_tgt_imp", D.imp, 32'h2408_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
